uart_rx_deserializer: RTL

UART receive path for the serial link. Oversamples RX_IN, detects the start bit and majority-votes each bit at mid-bit. Reassembles an LSB-first data word, checks optional parity and the stop bit, then presents the word on a parallel bus with a one-cycle valid strobe. Sits at the link input and feeds the parallel consumer.

---
 rtl/uart_rx_deserializer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start detect, 3-sample majority
// vote at mid-bit, LSB-first reassembly, optional parity and stop checks.
// Results are presented as registered one-cycle strobes.
module uart_rx_deserializer #(
  parameter int Data_Width = 8,
  parameter int Prescale   = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [Data_Width-1:0] P_Data,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err,
  output logic                  Busy
);

  localparam int EW = $clog2(Prescale);
  localparam int BW = $clog2(Data_Width + 1);

  localparam logic [EW-1:0] EDGE_ONE  = EW'(1);
  localparam logic [EW-1:0] EDGE_S0   = EW'(Prescale / 2 - 1);
  localparam logic [EW-1:0] EDGE_S1   = EW'(Prescale / 2);
  localparam logic [EW-1:0] EDGE_RES  = EW'(Prescale / 2 + 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(Prescale - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(Data_Width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [EW-1:0]           r_edge_cnt;
  logic [BW-1:0]           r_bit_cnt;
  logic                    r_s0;
  logic                    r_s1;
  logic                    r_par_en;
  logic                    r_par_typ;
  logic                    r_par_fail;
  logic                    r_stp_fail;
  logic [Data_Width-1:0]   r_shift;

  logic w_start_det;
  logic w_edge_last;
  logic w_resolve;
  logic w_maj;
  logic w_par_exp;
  logic w_valid_next;
  logic w_par_err_next;
  logic w_stp_err_next;
  logic w_busy_next;

  assign w_start_det = (r_state == IDLE) && !RX_IN;
  assign w_edge_last = (r_state != IDLE) && (r_edge_cnt == EDGE_LAST);
  assign w_resolve   = (r_state != IDLE) && (r_edge_cnt == EDGE_RES);
  // Third sample is the live line value on the resolve edge.
  assign w_maj       = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
  assign w_par_exp   = (^r_shift) ^ r_par_typ;

  // State register
  always_ff @(posedge clk) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (!RX_IN) w_state_next = START;
      START: begin
        if (w_resolve && w_maj) w_state_next = IDLE;   // glitch, not a start bit
        else if (w_edge_last)   w_state_next = DATA;
      end
      DATA: begin
        if (w_edge_last && (r_bit_cnt == BIT_LAST))
          w_state_next = r_par_en ? PARITY : STOP;
      end
      PARITY: if (w_edge_last) w_state_next = STOP;
      STOP:   if (w_edge_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output next-value logic; the stop vote may resolve on the final edge itself
  always_comb begin
    w_valid_next   = 1'b0;
    w_par_err_next = 1'b0;
    w_stp_err_next = 1'b0;
    w_busy_next    = (w_state_next != IDLE);
    if ((r_state == STOP) && w_edge_last) begin
      w_par_err_next = r_par_fail;
      w_stp_err_next = r_stp_fail | (w_resolve & ~w_maj);
      w_valid_next   = ~w_par_err_next & ~w_stp_err_next;
    end
  end

  // Edge and data-bit counters
  always_ff @(posedge clk) begin
    if (RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (r_state == IDLE)
        r_edge_cnt <= RX_IN ? '0 : EDGE_ONE;
      else if ((w_state_next == IDLE) || w_edge_last)
        r_edge_cnt <= '0;
      else
        r_edge_cnt <= r_edge_cnt + EDGE_ONE;

      if (r_state != DATA)
        r_bit_cnt <= '0;
      else if (w_edge_last)
        r_bit_cnt <= r_bit_cnt + BIT_ONE;
    end
  end

  // Capture the two early mid-bit samples
  always_ff @(posedge clk) begin
    if (RST) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else if (r_state != IDLE) begin
      if (r_edge_cnt == EDGE_S0) r_s0 <= RX_IN;
      if (r_edge_cnt == EDGE_S1) r_s1 <= RX_IN;
    end
  end

  // Frame configuration latch, shift register and fail flags
  always_ff @(posedge clk) begin
    if (RST) begin
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_fail <= 1'b0;
      r_stp_fail <= 1'b0;
      r_shift    <= '0;
    end else if (w_start_det) begin
      r_par_en   <= PAR_EN;
      r_par_typ  <= PAR_TYP;
      r_par_fail <= 1'b0;
      r_stp_fail <= 1'b0;
    end else if (w_resolve) begin
      case (r_state)
        DATA:    r_shift <= {w_maj, r_shift[Data_Width-1:1]};
        PARITY:  if (w_maj != w_par_exp) r_par_fail <= 1'b1;
        STOP:    if (!w_maj) r_stp_fail <= 1'b1;
        default: ;
      endcase
    end
  end

  // Registered outputs; P_Data only changes on a clean frame
  always_ff @(posedge clk) begin
    if (RST) begin
      P_Data     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Data_Valid <= w_valid_next;
      Par_Err    <= w_par_err_next;
      Stp_Err    <= w_stp_err_next;
      Busy       <= w_busy_next;
      if (w_valid_next) P_Data <= r_shift;
    end
  end

endmodule
